// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for APB completers.
//   - FSM state encoding (IDLE / ACCESS)
//   - APB address / data / strobe widths
//   - PPROT bit positions
//   - default identification value for register 0
//   - latched request record captured in the setup phase
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int APB_SW = APB_DW / 8;

  // Register index field is paddr[7:2]
  localparam int IDX_W = 6;

  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

  localparam logic [APB_DW-1:0] APB_ID_DEFAULT = 32'hA5B3_0001;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic              err;
    logic [IDX_W-1:0]  idx;
    logic [APB_DW-1:0] wdata;
    logic [APB_SW-1:0] strb;
  } apb_req_t;

endpackage

// File: rtl/apb_slv_decode.sv
// apb_slv_decode: combinational address decode for a word-indexed register
// file behind an APB completer.
// Optional feature macro: APB_SLV_SECURE_EN (upper half of the registers is
// secure; non-secure accesses to it are errors).
// Ports:
//   paddr_i   byte address
//   pwrite_i  1 = write
//   pprot_i   protection attributes (only used with APB_SLV_SECURE_EN)
//   idx_o     register index, paddr[7:2]
//   err_o     access error (misaligned, out of window, no such register,
//             write to read-only register 0, secure violation)
module apb_slv_decode
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic [APB_AW-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [2:0]        pprot_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              err_o
);

  logic misalign, out_win, no_reg, ro_wr, sec_err;

  assign idx_o    = paddr_i[7:2];
  assign misalign = |paddr_i[1:0];
  assign out_win  = |paddr_i[APB_AW-1:8];
  assign no_reg   = int'(idx_o) >= NUM_REGS;
  assign ro_wr    = pwrite_i && (idx_o == '0);

`ifdef APB_SLV_SECURE_EN
  logic unused_prot;
  assign unused_prot = ^{pprot_i[PPROT_PRIV], pprot_i[PPROT_INSTR]};
  assign sec_err     = pprot_i[PPROT_NSEC] && (int'(idx_o) >= NUM_REGS / 2);
`else
  logic unused_prot;
  assign unused_prot = ^pprot_i;
  assign sec_err     = 1'b0;
`endif

  assign err_o = misalign | out_win | no_reg | ro_wr | sec_err;

endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer with a byte-strobed 32-bit register file.
// Register 0 is read-only and holds ID_VALUE; registers 1..NUM_REGS-1 are R/W.
// Every access phase is stretched by WAIT_CYCLES wait states.
// Optional feature macro: APB_SLV_SECURE_EN (handled inside apb_slv_decode).
// Ports:
//   pclk, presetn        clock, async active-low reset
//   psel, penable        APB select / access phase
//   pwrite, paddr        direction, byte address
//   pwdata, pstrb        write data, byte strobes
//   pprot                protection attributes
//   prdata               read data (valid with pready in a read)
//   pready               transfer complete (combinational from state)
//   pslverr              error response, only ever high with pready
//   regs_flat            all registers, reg i at [i*32+31:i*32]
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [APB_DW-1:0] ID_VALUE    = APB_ID_DEFAULT
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [APB_AW-1:0]        paddr,
  input  logic [APB_DW-1:0]        pwdata,
  input  logic [APB_SW-1:0]        pstrb,
  input  logic [2:0]               pprot,
  output logic [APB_DW-1:0]        prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_REGS*32-1:0]   regs_flat
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  apb_state_e                     state_q;
  logic [3:0]                     cnt_q;
  apb_req_t                       req_q;
  logic [APB_DW-1:0]              prdata_q, rdata_d, rd_sel;
  logic [NUM_REGS-1:1][APB_DW-1:0] regs_q;

  logic [IDX_W-1:0] dec_idx;
  logic             dec_err;
  logic             complete, commit;

  apb_slv_decode #(.NUM_REGS(NUM_REGS)) u_decode (
    .paddr_i  (paddr),
    .pwrite_i (pwrite),
    .pprot_i  (pprot),
    .idx_o    (dec_idx),
    .err_o    (dec_err)
  );

  // Read mux over the live address; read data is captured in the setup phase
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(dec_idx) == i) rd_sel = (i == 0) ? ID_VALUE : regs_q[i];
    end
  end

  assign rdata_d = (pwrite || dec_err) ? '0 : rd_sel;

  assign pready   = (state_q == ST_ACCESS) && (cnt_q == '0);
  assign pslverr  = req_q.err & pready;
  assign prdata   = prdata_q;
  assign complete = pready && psel && penable;
  assign commit   = complete && req_q.write && !req_q.err;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      prdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (psel && !penable) begin
            state_q  <= ST_ACCESS;
            cnt_q    <= CNT_INIT;
            req_q    <= '{write: pwrite, err: dec_err, idx: dec_idx,
                          wdata: pwdata, strb: pstrb};
            prdata_q <= rdata_d;
          end
        end
        ST_ACCESS: begin
          // Dropping psel abandons the transfer; nothing is written
          if (!psel)              state_q <= ST_IDLE;
          else if (cnt_q != '0)   cnt_q   <= cnt_q - 4'd1;
          else if (penable)       state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      regs_q <= '0;
    end else if (commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (int'(req_q.idx) == i) begin
          for (int b = 0; b < APB_SW; b++) begin
            if (req_q.strb[b]) regs_q[i][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  assign regs_flat = {regs_q, ID_VALUE};

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

`ifdef APB_SLV_SECURE_EN
  localparam bit SEC = 1'b1;
`else
  localparam bit SEC = 1'b0;
`endif

  localparam logic [31:0]  ID      = 32'hA5B3_0001;
  localparam logic [255:0] RST_IMG = {224'b0, ID};

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel0, psel3, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic [255:0] regs0, regs3;

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .regs_flat(regs0));

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(3)) u_dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
    .regs_flat(regs3));

  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          err;
    int          waits;
    string       name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input string name, input bit d3, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p,
                      input logic [31:0] er, input bit ee);
    exp_t e;
    int   n;
    e.rd = !wr; e.rdata = er; e.err = ee; e.waits = d3 ? 3 : 0; e.name = name;
    q.push_back(e);
    @(posedge pclk); #1;
    psel0 = !d3; psel3 = d3; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0;
    @(negedge pclk);
    while (!(d3 ? pready3 : pready0) && n < 50) begin
      n++;
      @(negedge pclk);
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL %s: pready timeout after %0d cycles, required within 50", name, n);
      void'(q.pop_back());
    end
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  // Monitor: compares every completed transfer against the queued expectation
  initial begin
    int   wcnt;
    bit   act, rdy, err;
    logic [31:0] rd;
    exp_t e;
    wcnt = 0;
    forever begin
      @(negedge pclk);
      act = (psel0 || psel3) && penable && presetn;
      rdy = psel3 ? pready3  : pready0;
      err = psel3 ? pslverr3 : pslverr0;
      rd  = psel3 ? prdata3  : prdata0;
      if (!act) begin
        wcnt = 0;
      end else if (!rdy) begin
        chk("pslverr_while_waiting", 256'(err), 256'(0));
        wcnt++;
      end else begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion: got a response, required none");
        end else begin
          e = q.pop_front();
          chk({e.name, "_waits"}, 256'(wcnt), 256'(e.waits));
          chk({e.name, "_pslverr"}, 256'(err), 256'(e.err));
          if (e.rd) chk({e.name, "_prdata"}, 256'(rd), 256'(e.rdata));
        end
        wcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b0;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready0",  256'(pready0),  256'(0));
    chk("rst_prdata0",  256'(prdata0),  256'(0));
    chk("rst_pslverr0", 256'(pslverr0), 256'(0));
    chk("rst_regs0",    regs0,          RST_IMG);
    chk("rst_pready3",  256'(pready3),  256'(0));
    chk("rst_regs3",    regs3,          RST_IMG);
    @(posedge pclk); #1 presetn = 1'b1;

    // Zero-wait DUT: basic write/read, strobes, back-to-back
    xfer("wr04",      0, 1, 32'h04, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0, 0);
    xfer("rd04",      0, 0, 32'h04, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF, 0);
    xfer("wr08_strb", 0, 1, 32'h08, 32'h1122_3344, 4'b0101, 3'b000, 32'h0, 0);
    xfer("rd08",      0, 0, 32'h08, 32'h0,         4'hF, 3'b000, 32'h0022_0044, 0);
    idle();
    // Error responses
    xfer("wr00_ro",   0, 1, 32'h00, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, 1);
    xfer("rd00",      0, 0, 32'h00, 32'h0,         4'h0, 3'b000, ID, 0);
    xfer("rd20_noreg",0, 0, 32'h20, 32'h0,         4'h0, 3'b000, 32'h0, 1);
    xfer("rd06_mis",  0, 0, 32'h06, 32'h0,         4'h0, 3'b000, 32'h0, 1);
    xfer("wr06_mis",  0, 1, 32'h06, 32'h1234_5678, 4'hF, 3'b000, 32'h0, 1);
    xfer("rd104_win", 0, 0, 32'h104, 32'h0,        4'h0, 3'b000, 32'h0, 1);
    xfer("rd04_again",0, 0, 32'h04, 32'h0,         4'h0, 3'b000, 32'hDEAD_BEEF, 0);
    // Strobe-free write is an OKAY no-op
    xfer("wr1c_nostrb",0,1, 32'h1C, 32'hFFFF_FFFF, 4'h0, 3'b000, 32'h0, 0);
    xfer("rd1c",      0, 0, 32'h1C, 32'h0,         4'h0, 3'b000, 32'h0, 0);
    // Secure window (reg 4 of 8) with non-secure and secure pprot
    xfer("wr10_nsec", 0, 1, 32'h10, 32'hCAFE_F00D, 4'hF, 3'b010, 32'h0, SEC);
    xfer("rd10_sec",  0, 0, 32'h10, 32'h0,         4'h0, 3'b000,
         SEC ? 32'h0 : 32'hCAFE_F00D, 0);
    xfer("wr10_sec",  0, 1, 32'h10, 32'h1234_5678, 4'hF, 3'b000, 32'h0, 0);
    xfer("rd10_nsec", 0, 0, 32'h10, 32'h0,         4'h0, 3'b010,
         SEC ? 32'h0 : 32'h1234_5678, SEC);
    idle();
    chk("regs0_img", regs0, {96'h0, 32'h1234_5678, 32'h0, 32'h0022_0044,
                             32'hDEAD_BEEF, ID});

    // Wait-state DUT
    xfer("w3_rd00",   1, 0, 32'h00, 32'h0,         4'h0, 3'b000, ID, 0);
    xfer("w3_wr04",   1, 1, 32'h04, 32'h0BAD_F00D, 4'b1100, 3'b000, 32'h0, 0);
    xfer("w3_rd04",   1, 0, 32'h04, 32'h0,         4'h0, 3'b000, 32'h0BAD_0000, 0);
    xfer("w3_wr00_ro",1, 1, 32'h00, 32'h0,         4'hF, 3'b000, 32'h0, 1);
    idle();

    // Reset pulled in the access phase of a write to 0x0C
    @(posedge pclk); #1;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = 32'h55AA_55AA; pstrb = 4'hF; pprot = 3'b000;
    @(posedge pclk); #1 penable = 1'b1;
    #2 presetn = 1'b0;
    #1 psel0 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("rstmid_pready0", 256'(pready0), 256'(0));
    @(posedge pclk); #1 presetn = 1'b1;
    @(negedge pclk);
    chk("rstmid_regs0", regs0, RST_IMG);
    chk("rstmid_regs3", regs3, RST_IMG);
    xfer("rst_rd0c",  0, 0, 32'h0C, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    xfer("rst_rd04",  0, 0, 32'h04, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    idle();

    // Master abort: psel dropped in the access phase
    @(posedge pclk); #1;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(posedge pclk); #1 psel0 = 1'b0; penable = 1'b1;
    @(posedge pclk); #1 penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready0", 256'(pready0), 256'(0));
    xfer("abort_rd14",0, 0, 32'h14, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    idle();

    repeat (3) @(posedge pclk);
    chk("queue_empty", 256'(q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
